// File: rtl/bpred_pkg.sv
// bpred_pkg: shared constants, metadata struct and counter helpers for the
// fetch-stage branch predictor. Optional feature macro: BPRED_RAS_EN.
package bpred_pkg;

    localparam int PKG_PHT_IDX_W = 10;
    localparam int PKG_MEM_IDX_W = 8;
    localparam int PKG_RAS_DEPTH = 8;
    localparam int META_W        = PKG_PHT_IDX_W + 2;

    // Counters are stored XORed with this value so an all-zero (unwritten)
    // PHT reads back as weakly-not-taken.
    localparam logic [1:0] PHT_INIT = 2'b01;

    localparam logic [5:0] OP_CALL  = 6'h00;
    localparam logic [5:0] OP_BR    = 6'h06;
    localparam logic [5:0] OP_BGE   = 6'h0E;
    localparam logic [5:0] OP_BLT   = 6'h16;
    localparam logic [5:0] OP_BNE   = 6'h1E;
    localparam logic [5:0] OP_BEQ   = 6'h26;
    localparam logic [5:0] OP_BGEU  = 6'h2E;
    localparam logic [5:0] OP_BLTU  = 6'h36;
    localparam logic [5:0] OP_RTYPE = 6'h3A;

    localparam logic [5:0] OPX_RET   = 6'h05;
    localparam logic [5:0] OPX_JMP   = 6'h0D;
    localparam logic [5:0] OPX_CALLR = 6'h1D;

    typedef struct packed {
        logic [PKG_PHT_IDX_W-1:0] idx;
        logic [1:0]               ctr;
    } bpred_meta_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    function automatic logic is_cond(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

endpackage

// File: rtl/bpred_if.sv
// bpred_if: fetch/execute side bundle of the branch predictor.
// master = pipeline / preload side, slave = predictor.
interface bpred_if;
    import bpred_pkg::*;

    logic              insnMem_wren;
    logic [7:0]        insnMem_addr_w;
    logic [31:0]       insnMem_data_w;
    logic [3:0]        byte_en;
    logic [29:0]       up_btb_data;
    logic [8:0]        up_carry_data;
    logic [8:0]        bit_carry;
    logic              soin_bpredictor_stall;
    logic              bpredictor_fetch_p_dir;
    logic [META_W-1:0] bpredictor_fetch_bimodal;
    logic              execute_bpredictor_update;
    logic [31:0]       execute_bpredictor_PC4;
    logic [31:0]       execute_bpredictor_target;
    logic              execute_bpredictor_dir;
    logic              execute_bpredictor_miss;
    logic [META_W-1:0] execute_bpredictor_bimodal;
    logic              execute_missPred;
    logic              execute_c_r_after_r;
    logic              execute_isCall;
    logic [31:0]       soin_bpredictor_debug_sel;
    logic [31:0]       bpredictor_soin_debug;

    modport master (
        output insnMem_wren, insnMem_addr_w, insnMem_data_w, byte_en, up_btb_data, up_carry_data,
        output soin_bpredictor_stall, execute_bpredictor_update, execute_bpredictor_PC4,
        output execute_bpredictor_target, execute_bpredictor_dir, execute_bpredictor_miss,
        output execute_bpredictor_bimodal, execute_missPred, execute_c_r_after_r, execute_isCall,
        output soin_bpredictor_debug_sel,
        input  bit_carry, bpredictor_fetch_p_dir, bpredictor_fetch_bimodal, bpredictor_soin_debug
    );

    modport slave (
        input  insnMem_wren, insnMem_addr_w, insnMem_data_w, byte_en, up_btb_data, up_carry_data,
        input  soin_bpredictor_stall, execute_bpredictor_update, execute_bpredictor_PC4,
        input  execute_bpredictor_target, execute_bpredictor_dir, execute_bpredictor_miss,
        input  execute_bpredictor_bimodal, execute_missPred, execute_c_r_after_r, execute_isCall,
        input  soin_bpredictor_debug_sel,
        output bit_carry, bpredictor_fetch_p_dir, bpredictor_fetch_bimodal, bpredictor_soin_debug
    );
endinterface

// File: rtl/bpred_ras.sv
// bpred_ras: circular return address stack (used only with BPRED_RAS_EN).
// Overflow overwrites the oldest entry, underflow simply wraps the pointer.
module bpred_ras
    import bpred_pkg::*;
#(
    parameter int DEPTH = PKG_RAS_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_push_data,
    output logic [31:0] o_top
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_ptr;
    logic [31:0]      r_stack [0:DEPTH-1];
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_wr_idx;

    // Pop-then-push in one cycle replaces the current top in place.
    assign w_top_idx = r_ptr - 1'b1;
    assign w_wr_idx  = i_pop ? w_top_idx : r_ptr;
    assign o_top     = r_stack[w_top_idx];

    // Stack pointer: net movement of push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ptr <= '0;
        else if (i_push && !i_pop)
            r_ptr <= r_ptr + 1'b1;
        else if (i_pop && !i_push)
            r_ptr <= r_ptr - 1'b1;
    end

    // Stack storage, not reset.
    always_ff @(posedge clk) begin
        if (i_push)
            r_stack[w_wr_idx] <= i_push_data;
    end
endmodule

// File: rtl/bpred_top.sv
// bpred_top: fetch PC, instruction memory, BTB, carry table and gshare PHT.
// Optional feature macro: BPRED_RAS_EN (return address stack for ret).
module bpred_top
    import bpred_pkg::*;
#(
    parameter int PHT_IDX_W = PKG_PHT_IDX_W,
    parameter int MEM_IDX_W = PKG_MEM_IDX_W,
    parameter int RAS_DEPTH = PKG_RAS_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    bpred_if.slave bus
);
    localparam int PHT_DEPTH = 1 << PHT_IDX_W;
    localparam int MEM_DEPTH = 1 << MEM_IDX_W;

    logic [31:0]          r_pc;
    logic [PHT_IDX_W-1:0] r_ghr;
    logic [31:0]          r_br_cnt;
    logic [31:0]          r_miss_cnt;
    logic                 r_p_dir;
    logic [META_W-1:0]    r_bimodal;
    logic [8:0]           r_carry;

    logic [29:0]          r_btb   [0:MEM_DEPTH-1];
    logic [8:0]           r_ctab  [0:MEM_DEPTH-1];
    logic [1:0]           r_pht   [0:PHT_DEPTH-1];

    logic [MEM_IDX_W-1:0] w_fidx;
    logic [31:0]          w_insn;
    logic [5:0]           w_op;
    logic [5:0]           w_opx;
    logic [PHT_IDX_W-1:0] w_idx;
    logic [1:0]           w_ctr;
    logic [31:0]          w_pc4;
    logic [31:0]          w_br_tgt;
    logic [31:0]          w_btb_tgt;
    logic [31:0]          w_ret_tgt;
    logic [31:0]          w_next_pc;
    logic                 w_pdir;
    bpred_meta_t          w_upd_meta;

    genvar gi;

    assign w_fidx    = r_pc[MEM_IDX_W+1:2];
    assign w_op      = w_insn[5:0];
    assign w_opx     = w_insn[16:11];
    assign w_idx     = r_pc[PHT_IDX_W+1:2] ^ r_ghr;
    assign w_ctr     = r_pht[w_idx] ^ PHT_INIT;
    assign w_pc4     = r_pc + 32'd4;
    assign w_br_tgt  = w_pc4 + {{16{w_insn[21]}}, w_insn[21:6]};
    assign w_btb_tgt = {r_btb[w_fidx], 2'b00};
    assign w_upd_meta = bus.execute_bpredictor_bimodal;

    // Instruction memory split into byte lanes so each lane honours its enable.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [0:MEM_DEPTH-1];
            always_ff @(posedge clk) begin
                if (bus.insnMem_wren && bus.byte_en[gi])
                    r_lane[bus.insnMem_addr_w] <= bus.insnMem_data_w[8*gi +: 8];
            end
            assign w_insn[8*gi +: 8] = r_lane[w_fidx];
        end
    endgenerate

    // BTB and carry side-table are written whole alongside the instruction.
    always_ff @(posedge clk) begin
        if (bus.insnMem_wren) begin
            r_btb[bus.insnMem_addr_w]  <= bus.up_btb_data;
            r_ctab[bus.insnMem_addr_w] <= bus.up_carry_data;
        end
    end

`ifdef BPRED_RAS_EN
    bpred_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (bus.execute_isCall),
        .i_pop       (bus.execute_c_r_after_r),
        .i_push_data (bus.execute_bpredictor_PC4),
        .o_top       (w_ret_tgt)
    );
    logic w_unused;
    assign w_unused = &{1'b0, bus.soin_bpredictor_debug_sel[31:2]};
`else
    assign w_ret_tgt = w_btb_tgt;
    logic w_unused;
    assign w_unused = &{1'b0, bus.soin_bpredictor_debug_sel[31:2],
                        bus.execute_isCall, bus.execute_c_r_after_r};
`endif

    // Decode the fetched word and choose the predicted next PC.
    always_comb begin
        w_next_pc = w_pc4;
        w_pdir    = 1'b0;
        if (is_cond(w_op)) begin
            w_pdir = w_ctr[1];
            if (w_ctr[1])
                w_next_pc = w_br_tgt;
        end else if (w_op == OP_BR) begin
            w_pdir    = 1'b1;
            w_next_pc = w_br_tgt;
        end else if (w_op == OP_CALL) begin
            w_next_pc = {r_pc[31:28], w_insn[31:6], 2'b00};
        end else if (w_op == OP_RTYPE) begin
            if (w_opx == OPX_RET)
                w_next_pc = w_ret_tgt;
            else if ((w_opx == OPX_CALLR) || (w_opx == OPX_JMP))
                w_next_pc = w_btb_tgt;
        end
    end

    // Fetch PC and registered prediction; a redirect beats both stall and prediction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= '0;
            r_p_dir   <= 1'b0;
            r_bimodal <= '0;
            r_carry   <= '0;
        end else begin
            if (bus.execute_missPred)
                r_pc <= bus.execute_bpredictor_dir ? bus.execute_bpredictor_target
                                                   : bus.execute_bpredictor_PC4;
            else if (!bus.soin_bpredictor_stall)
                r_pc <= w_next_pc;
            if (!bus.soin_bpredictor_stall) begin
                r_p_dir   <= w_pdir;
                r_bimodal <= {w_idx, w_ctr};
                r_carry   <= r_ctab[w_fidx];
            end
        end
    end

    // Global history and statistics advance on every resolved conditional branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghr      <= '0;
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else if (bus.execute_bpredictor_update) begin
            r_ghr    <= {r_ghr[PHT_IDX_W-2:0], bus.execute_bpredictor_dir};
            r_br_cnt <= r_br_cnt + 32'd1;
            if (bus.execute_bpredictor_miss)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    // PHT training from the counter value fetch handed to execute.
    always_ff @(posedge clk) begin
        if (bus.execute_bpredictor_update)
            r_pht[w_upd_meta.idx] <= sat_update(w_upd_meta.ctr, bus.execute_bpredictor_dir) ^ PHT_INIT;
    end

    // Debug read mux.
    always_comb begin
        case (bus.soin_bpredictor_debug_sel[1:0])
            2'd0:    bus.bpredictor_soin_debug = r_pc;
            2'd1:    bus.bpredictor_soin_debug = r_br_cnt;
            2'd2:    bus.bpredictor_soin_debug = r_miss_cnt;
            default: bus.bpredictor_soin_debug = {{(32-PHT_IDX_W){1'b0}}, r_ghr};
        endcase
    end

    assign bus.bpredictor_fetch_p_dir   = r_p_dir;
    assign bus.bpredictor_fetch_bimodal = r_bimodal;
    assign bus.bit_carry                = r_carry;
endmodule

// File: tb/tb_bpred_top.sv
// tb_bpred_top: directed scoreboard bench for bpred_top.
// Stimulus pushes expected observations tagged with a cycle number; a
// negedge monitor compares them against the DUT outputs.
module tb_bpred_top;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bpred_if bus ();

    bpred_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int K_DBG = 0, K_PDIR = 1, K_BIM = 2, K_CARRY = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_DBG:   return bus.bpredictor_soin_debug;
            K_PDIR:  return {31'b0, bus.bpredictor_fetch_p_dir};
            K_BIM:   return {20'b0, bus.bpredictor_fetch_bimodal};
            default: return {23'b0, bus.bit_carry};
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin : monitor
        int k;
        logic [31:0] got;
        k = 0;
        while (k < exp_q.size()) begin
            if (exp_q[k].cyc == cyc_cnt) begin
                got = observe(exp_q[k].kind);
                checks++;
                if (got !== exp_q[k].val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                             exp_q[k].name, got, exp_q[k].val, cyc_cnt);
                end else begin
                    $display("check %s ok: %0h (cycle %0d)", exp_q[k].name, got, cyc_cnt);
                end
                exp_q.delete(k);
            end else if (exp_q[k].cyc < cyc_cnt) begin
                checks++;
                errors++;
                $display("FAIL %s: not sampled, expected %0h at cycle %0d",
                         exp_q[k].name, exp_q[k].val, exp_q[k].cyc);
                exp_q.delete(k);
            end else begin
                k++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int c, input int kind, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [29:0] btb, input logic [8:0] cr);
        bus.insnMem_wren   = 1'b1;
        bus.insnMem_addr_w = a;
        bus.insnMem_data_w = d;
        bus.byte_en        = be;
        bus.up_btb_data    = btb;
        bus.up_carry_data  = cr;
        tick();
        bus.insnMem_wren   = 1'b0;
    endtask

    task automatic train(input logic [11:0] bim, input logic dir, input logic miss);
        bus.execute_bpredictor_update  = 1'b1;
        bus.execute_bpredictor_bimodal = bim;
        bus.execute_bpredictor_dir     = dir;
        bus.execute_bpredictor_miss    = miss;
        tick();
        bus.execute_bpredictor_update  = 1'b0;
        bus.execute_bpredictor_miss    = 1'b0;
    endtask

    // Redirect from execute; debug sel must be 0 so the PC is visible next cycle.
    task automatic redirect(input logic dir, input logic [31:0] tgt, input logic [31:0] pc4,
                            input logic is_call, input logic [31:0] exp_pc, input string n);
        bus.execute_missPred          = 1'b1;
        bus.execute_bpredictor_dir    = dir;
        bus.execute_bpredictor_target = tgt;
        bus.execute_bpredictor_PC4    = pc4;
        bus.execute_isCall            = is_call;
        exp_at(cyc_cnt + 1, K_DBG, exp_pc, n);
        tick();
        bus.execute_missPred = 1'b0;
        bus.execute_isCall   = 1'b0;
    endtask

    // One unstalled fetch cycle with its expected next PC and direction.
    task automatic step(input logic [31:0] exp_pc, input logic exp_dir, input string n);
        bus.soin_bpredictor_stall = 1'b0;
        exp_at(cyc_cnt + 1, K_DBG, exp_pc, {n, "_pc"});
        exp_at(cyc_cnt + 1, K_PDIR, {31'b0, exp_dir}, {n, "_pdir"});
        tick();
    endtask

    initial begin
        reset = 1'b0;
        bus.insnMem_wren = 0; bus.insnMem_addr_w = 0; bus.insnMem_data_w = 0;
        bus.byte_en = 0; bus.up_btb_data = 0; bus.up_carry_data = 0;
        bus.soin_bpredictor_stall = 1; bus.execute_bpredictor_update = 0;
        bus.execute_bpredictor_PC4 = 0; bus.execute_bpredictor_target = 0;
        bus.execute_bpredictor_dir = 0; bus.execute_bpredictor_miss = 0;
        bus.execute_bpredictor_bimodal = 0; bus.execute_missPred = 0;
        bus.execute_c_r_after_r = 0; bus.execute_isCall = 0;
        bus.soin_bpredictor_debug_sel = 0;

        // Reset state
        tick(); tick();
        exp_at(cyc_cnt, K_DBG, 32'd0, "rst_pc");
        exp_at(cyc_cnt, K_PDIR, 32'd0, "rst_pdir");
        exp_at(cyc_cnt, K_BIM, 32'd0, "rst_bim");
        exp_at(cyc_cnt, K_CARRY, 32'd0, "rst_carry");
        tick();
        bus.soin_bpredictor_debug_sel = 32'd3;
        exp_at(cyc_cnt, K_DBG, 32'd0, "rst_ghr");
        tick();
        bus.soin_bpredictor_debug_sel = 32'd0;
        reset = 1'b1;

        // Preload (fetch frozen)
        preload(8'd0,  32'h0000_0426, 4'b1111, 30'd0,  9'h1A5); // beq +16
        preload(8'd1,  32'h0000_0800, 4'b1111, 30'd0,  9'h000); // call 0x80
        preload(8'd1,  32'hFFFF_FF06, 4'b0001, 30'd0,  9'h000); // lane 0 only -> br +32
        preload(8'd4,  32'h0000_0200, 4'b1111, 30'd0,  9'h000); // call imm26=8
        preload(8'd8,  32'h0000_E83A, 4'b1111, 30'd12, 9'h000); // callr
        preload(8'd12, 32'h0000_283A, 4'b1111, 30'd50, 9'h000); // ret
        preload(8'd37, 32'h0000_001E, 4'b1111, 30'd0,  9'h000); // bne +0

        // Training: PHT[32] 3->3->2, PHT[5] 2->3; GHR 0->1->2->5
        train(12'h083, 1'b1, 1'b0);
        train(12'h083, 1'b0, 1'b1);
        train(12'h016, 1'b1, 1'b0);
        bus.soin_bpredictor_debug_sel = 32'd1;
        exp_at(cyc_cnt, K_DBG, 32'd3, "dbg_br_cnt");
        tick();
        bus.soin_bpredictor_debug_sel = 32'd2;
        exp_at(cyc_cnt, K_DBG, 32'd1, "dbg_miss_cnt");
        tick();
        bus.soin_bpredictor_debug_sel = 32'd3;
        exp_at(cyc_cnt, K_DBG, 32'd5, "dbg_ghr");
        tick();
        bus.soin_bpredictor_debug_sel = 32'd0;

        // beq at PC 0, idx 0^5=5, ctr 3 -> taken to 20
        exp_at(cyc_cnt + 1, K_BIM, 32'h017, "beq_bim");
        exp_at(cyc_cnt + 1, K_CARRY, 32'h1A5, "beq_carry");
        step(32'd20, 1'b1, "beq");
        bus.soin_bpredictor_stall = 1'b1;
        exp_at(cyc_cnt + 1, K_DBG, 32'd20, "stall_pc");
        exp_at(cyc_cnt + 1, K_PDIR, 32'd1, "stall_pdir");
        exp_at(cyc_cnt + 1, K_BIM, 32'h017, "stall_bim");
        tick();

        // Redirects while stalled
        redirect(1'b1, 32'd128, 32'd0,   1'b0, 32'd128, "mp_taken");
        redirect(1'b0, 32'd0,   32'd132, 1'b0, 32'd132, "mp_not_taken");
        redirect(1'b1, 32'd148, 32'd0,   1'b0, 32'd148, "mp_to_148");

        // bne at PC 148, idx 37^5=32, ctr 2 -> taken to 152
        exp_at(cyc_cnt + 1, K_BIM, 32'h082, "bne_bim");
        step(32'd152, 1'b1, "bne");
        bus.soin_bpredictor_stall = 1'b1;

        // call -> callr -> ret, with a call resolved (push 36) on the redirect
        redirect(1'b1, 32'd16, 32'd36, 1'b1, 32'd16, "mp_to_16");
        step(32'd32, 1'b0, "call");
        step(32'd48, 1'b0, "callr");
`ifdef BPRED_RAS_EN
        step(32'd36, 1'b0, "ret_ras");
`else
        step(32'd200, 1'b0, "ret_btb");
`endif
        bus.soin_bpredictor_stall = 1'b1;

        // Byte-lane write produced br +32 at PC 4
        redirect(1'b1, 32'd4, 32'd0, 1'b0, 32'd4, "mp_to_4");
        step(32'd40, 1'b1, "br_byte_en");

        // Redirect beats the unstalled prediction
        bus.soin_bpredictor_stall = 1'b0;
        redirect(1'b0, 32'd0, 32'd64, 1'b0, 32'd64, "mp_over_pred");
        bus.soin_bpredictor_stall = 1'b1;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
